// File: rtl/ptp_mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store; each access is LAT cycles plus a response cycle.
// Requests wait (stall) until their one-cycle ack. Load/store wins ties unless fetch has starved STARVE grants. halt blocks new grants.
module ptp_mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_ls,
    input  logic          halt,
    output logic          idle
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t         state, state_nxt;
    logic           grant_if, grant_ls;
    logic           owner_if;
    logic           we_q;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  starve_cnt;
    logic           last_cycle;

    assign last_cycle = (state == S_ACCESS) && (cnt == CW'(0));

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!halt) begin
                    if (ls_req && (!if_req || starve_cnt != SW'(STARVE)))
                        grant_ls = 1'b1;
                    else if (if_req)
                        grant_if = 1'b1;
                end
                if (grant_if || grant_ls)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt == CW'(0))
                    state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            owner_if   <= 1'b0;
            we_q       <= 1'b0;
            cnt        <= '0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
        end else begin
            state  <= state_nxt;
            if_ack <= last_cycle && owner_if;
            ls_ack <= last_cycle && !owner_if;
            if (grant_if || grant_ls) begin
                owner_if  <= grant_if;
                we_q      <= grant_ls && ls_we;
                mem_addr  <= grant_if ? if_addr : ls_addr;
                mem_wdata <= grant_if ? '0 : ls_wdata;
                cnt       <= CW'(LAT - 1);
            end
            // Fetch progress resets the starvation window; so does a load/store nobody was waiting behind.
            if (grant_if)
                starve_cnt <= '0;
            else if (grant_ls) begin
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt != SW'(STARVE))
                    starve_cnt <= starve_cnt + SW'(1);
            end
            if (state == S_ACCESS) begin
                if (cnt != CW'(0))
                    cnt <= cnt - CW'(1);
                else if (owner_if)
                    if_rdata <= mem_rdata;
                else if (!we_q)
                    ls_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en   = (state == S_ACCESS);
    assign mem_we   = mem_en && we_q;
    assign idle     = (state == S_IDLE);
    assign stall_if = if_req && !if_ack;
    assign stall_ls = ls_req && !ls_ack;
endmodule

// File: tb/tb_ptp_mem_arbiter.sv
module tb_ptp_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we, halt;
    logic [15:0] if_addr, ls_addr, ls_wdata;
    logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, ls_ack, mem_en, mem_we, stall_if, stall_ls, idle;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cur_c  = 0;
    string test   = "reset";
    int    wr_cycles = 0;
    logic [15:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;

    ptp_mem_arbiter #(.AW(16), .DW(16), .LAT(2), .STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_ls(stall_ls),
        .halt(halt), .idle(idle)
    );

    always #5 clk = ~clk;

    // Fixed memory image for reads; stores are logged rather than written back.
    always_comb begin
        case (mem_addr)
            16'h0010: mem_rdata = 16'hA5C3;
            16'h0020: mem_rdata = 16'h5A5A;
            16'h0100: mem_rdata = 16'h1234;
            16'h0300: mem_rdata = 16'h7777;
            default:  mem_rdata = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_cycles  <= wr_cycles + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cycle %0d: got %h expected %h", test, tag, cur_c, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input int c, input logic [31:0] en_m, we_m, ia_m, la_m, si_m, sl_m, id_m);
        cur_c = c;
        check("mem_en",   {31'd0, mem_en},   {31'd0, en_m[c]});
        check("mem_we",   {31'd0, mem_we},   {31'd0, we_m[c]});
        check("if_ack",   {31'd0, if_ack},   {31'd0, ia_m[c]});
        check("ls_ack",   {31'd0, ls_ack},   {31'd0, la_m[c]});
        check("stall_if", {31'd0, stall_if}, {31'd0, si_m[c]});
        check("stall_ls", {31'd0, stall_ls}, {31'd0, sl_m[c]});
        check("idle",     {31'd0, idle},     {31'd0, id_m[c]});
    endtask

    initial begin
        reset = 1'b1; if_req = 0; ls_req = 0; ls_we = 0; halt = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        nxt(); nxt();
        check("mem_en",    {31'd0, mem_en}, 32'd0);
        check("mem_we",    {31'd0, mem_we}, 32'd0);
        check("mem_addr",  {16'd0, mem_addr}, 32'd0);
        check("mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("if_rdata",  {16'd0, if_rdata}, 32'd0);
        check("ls_rdata",  {16'd0, ls_rdata}, 32'd0);
        check("acks",      {30'd0, if_ack, ls_ack}, 32'd0);
        check("idle",      {31'd0, idle}, 32'd1);
        reset = 1'b0;

        test = "single_fetch";
        for (int c = 0; c <= 4; c++) begin
            nxt();
            if (c == 0) begin if_addr = 16'h0010; if_req = 1; end
            if (c == 4) if_req = 0;
            #1;
            obs(c, 32'h6, 32'h0, 32'h8, 32'h0, 32'h7, 32'h0, 32'h11);
            if (c == 3) check("if_rdata", {16'd0, if_rdata}, 32'hA5C3);
        end

        test = "simultaneous";
        for (int c = 0; c <= 8; c++) begin
            nxt();
            if (c == 0) begin
                ls_req = 1; ls_we = 0; ls_addr = 16'h0100;
                if_req = 1; if_addr = 16'h0020;
            end
            if (c == 4) ls_req = 0;
            if (c == 8) if_req = 0;
            #1;
            obs(c, 32'h66, 32'h0, 32'h80, 32'h8, 32'h7F, 32'h7, 32'h111);
            if (c == 1) check("mem_addr_ls", {16'd0, mem_addr}, 32'h0100);
            if (c == 3) check("ls_rdata", {16'd0, ls_rdata}, 32'h1234);
            if (c == 5) check("mem_addr_if", {16'd0, mem_addr}, 32'h0020);
            if (c == 7) check("if_rdata", {16'd0, if_rdata}, 32'h5A5A);
        end

        test = "starvation";
        for (int c = 0; c <= 20; c++) begin
            nxt();
            if (c == 0) begin
                ls_req = 1; ls_we = 0; ls_addr = 16'h0300;
                if_req = 1; if_addr = 16'h0010;
            end
            if (c == 20) begin ls_req = 0; if_req = 0; end
            #1;
            obs(c, 32'h66666, 32'h0, 32'h80000, 32'h8888, 32'h7FFFF, 32'hF7777, 32'h111111);
            if (c == 13) check("mem_addr_l4", {16'd0, mem_addr}, 32'h0300);
            if (c == 17) check("mem_addr_i", {16'd0, mem_addr}, 32'h0010);
            if (c == 15) check("ls_rdata", {16'd0, ls_rdata}, 32'h7777);
            if (c == 19) check("if_rdata", {16'd0, if_rdata}, 32'hA5C3);
        end

        test = "store";
        for (int c = 0; c <= 4; c++) begin
            nxt();
            if (c == 0) begin
                ls_req = 1; ls_we = 1; ls_addr = 16'h0200; ls_wdata = 16'hBEEF;
            end
            if (c == 4) begin ls_req = 0; ls_we = 0; end
            #1;
            obs(c, 32'h6, 32'h6, 32'h0, 32'h8, 32'h0, 32'h7, 32'h11);
            if (c == 1 || c == 2) begin
                check("mem_addr", {16'd0, mem_addr}, 32'h0200);
                check("mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
            end
            if (c == 3) check("ls_rdata_kept", {16'd0, ls_rdata}, 32'h7777);
        end
        check("write_cycles", wr_cycles, 32'd2);
        check("write_addr", {16'd0, last_waddr}, 32'h0200);
        check("write_data", {16'd0, last_wdata}, 32'hBEEF);

        test = "halt";
        for (int c = 0; c <= 9; c++) begin
            nxt();
            if (c == 0) begin
                ls_req = 1; ls_we = 0; ls_addr = 16'h0100;
                if_req = 1; if_addr = 16'h0020;
            end
            if (c == 1) halt = 1;
            if (c == 4) ls_req = 0;
            if (c == 9) begin if_req = 0; halt = 0; end
            #1;
            obs(c, 32'h6, 32'h0, 32'h0, 32'h8, 32'h1FF, 32'h7, 32'h3F1);
        end

        test = "reset_mid";
        for (int c = 0; c <= 10; c++) begin
            nxt();
            if (c == 0) begin if_req = 1; if_addr = 16'h0010; end
            if (c == 1) begin reset = 1; if_req = 0; end
            if (c == 2) reset = 0;
            if (c == 6) if_req = 1;
            if (c == 10) if_req = 0;
            #1;
            obs(c, 32'h182, 32'h0, 32'h200, 32'h0, 32'h1C1, 32'h0, 32'h47D);
            if (c == 2) check("if_rdata_cleared", {16'd0, if_rdata}, 32'h0);
            if (c == 9) check("if_rdata", {16'd0, if_rdata}, 32'hA5C3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
